// File: rtl/br_checkpoint_stack.sv
// Branch checkpoint storage: snapshots rename state per in-flight branch and
// returns a snapshot one cycle after a mispredict, squashing dependent slots.
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_NONE
`define BR_PR_NONE 2'd0
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'd1
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'd2
`endif

module br_checkpoint_stack #(
  parameter int BR_W      = 5,
  parameter int ARCH_N    = 32,
  parameter int PRF_IDX_W = 6,
  parameter int FL_PTR_W  = 6,
  parameter int ROB_PTR_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          is_br_i,
  input  logic [BR_W-1:0]               br_mask_i,
  input  logic [`BR_STATE_W-1:0]        br_state_i,
  input  logic [BR_W-1:0]               br_bit_i,
  input  logic [ARCH_N*PRF_IDX_W-1:0]   map_i,
  input  logic [FL_PTR_W-1:0]           fl_head_i,
  input  logic [ROB_PTR_W-1:0]          rob_tail_i,
  output logic [BR_W-1:0]               alloc_bit_o,
  output logic [BR_W-1:0]               slot_valid_o,
  output logic                          recover_valid_o,
  output logic [ARCH_N*PRF_IDX_W-1:0]   map_o,
  output logic [FL_PTR_W-1:0]           fl_head_o,
  output logic [ROB_PTR_W-1:0]          rob_tail_o,
  output logic [BR_W-1:0]               kill_mask_o
);

  localparam int MAP_W = ARCH_N * PRF_IDX_W;
  localparam int IDX_W = (BR_W > 1) ? $clog2(BR_W) : 1;

  logic [BR_W-1:0]      valid;
  logic [BR_W-1:0]      dep_mask [BR_W];
  logic [MAP_W-1:0]     map_mem  [BR_W];
  logic [FL_PTR_W-1:0]  fl_mem   [BR_W];
  logic [ROB_PTR_W-1:0] rob_mem  [BR_W];

  logic            is_wrong;
  logic            is_correct;
  logic [BR_W-1:0] eff;
  logic [BR_W-1:0] alloc_bit;
  logic [BR_W-1:0] kill;
  logic [IDX_W-1:0] sel;
  logic            found;

  assign is_wrong   = (br_state_i == `BR_PR_WRONG);
  assign is_correct = (br_state_i == `BR_PR_CORRECT);
  // A branch resolving correct this cycle frees its bit for immediate reuse.
  assign eff        = is_correct ? (br_mask_i & ~br_bit_i) : br_mask_i;

  always_comb begin
    alloc_bit = '0;
    found     = 1'b0;
    for (int i = 0; i < BR_W; i++) begin
      if (!found && !eff[i]) begin
        alloc_bit[i] = 1'b1;
        found        = 1'b1;
      end
    end
    if (!is_br_i || is_wrong) alloc_bit = '0;
  end

  always_comb begin
    kill = br_bit_i;
    sel  = '0;
    for (int k = 0; k < BR_W; k++) begin
      if (valid[k] && |(dep_mask[k] & br_bit_i)) kill[k] = 1'b1;
      if (br_bit_i[k]) sel = IDX_W'(k);
    end
  end

  // Control state: valid bits, dependency masks and the recovery pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid           <= '0;
      recover_valid_o <= 1'b0;
      kill_mask_o     <= '0;
      map_o           <= '0;
      fl_head_o       <= '0;
      rob_tail_o      <= '0;
      for (int k = 0; k < BR_W; k++) dep_mask[k] <= '0;
    end else begin
      recover_valid_o <= is_wrong;
      kill_mask_o     <= is_wrong ? kill : '0;
      if (is_wrong) begin
        map_o      <= map_mem[sel];
        fl_head_o  <= fl_mem[sel];
        rob_tail_o <= rob_mem[sel];
      end
      for (int k = 0; k < BR_W; k++) begin
        if (is_correct) begin
          dep_mask[k] <= dep_mask[k] & ~br_bit_i;
          if (br_bit_i[k]) valid[k] <= 1'b0;
        end
        if (is_wrong && kill[k]) valid[k] <= 1'b0;
        if (alloc_bit[k]) begin
          valid[k]    <= 1'b1;
          dep_mask[k] <= eff;
        end
      end
    end
  end

  // Snapshot payload is never cleared; only the valid bit tracks ownership.
  always_ff @(posedge clk) begin
    for (int k = 0; k < BR_W; k++) begin
      if (alloc_bit[k]) begin
        map_mem[k] <= map_i;
        fl_mem[k]  <= fl_head_i;
        rob_mem[k] <= rob_tail_i;
      end
    end
  end

  assign alloc_bit_o  = alloc_bit;
  assign slot_valid_o = valid;

endmodule

// File: tb/tb_br_checkpoint_stack.sv
// Directed self-checking bench for br_checkpoint_stack.
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_NONE
`define BR_PR_NONE 2'd0
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'd1
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'd2
`endif

module tb_br_checkpoint_stack;
  localparam int BR_W = 5, ARCH_N = 32, PRF_IDX_W = 6, FL_PTR_W = 6, ROB_PTR_W = 5;
  localparam int MAP_W = ARCH_N * PRF_IDX_W;

  logic clk = 1'b0, rst = 1'b1, is_br = 1'b0;
  logic [BR_W-1:0] br_mask = '0, br_bit = '0;
  logic [`BR_STATE_W-1:0] br_state = `BR_PR_NONE;
  logic [MAP_W-1:0] map_in = '0;
  logic [FL_PTR_W-1:0] fl_in = '0;
  logic [ROB_PTR_W-1:0] rob_in = '0;
  logic [BR_W-1:0] alloc_bit, slot_valid, kill_mask;
  logic recover_valid;
  logic [MAP_W-1:0] map_out;
  logic [FL_PTR_W-1:0] fl_out;
  logic [ROB_PTR_W-1:0] rob_out;

  int total = 0;
  int bad = 0;

  br_checkpoint_stack dut (
    .clk(clk), .rst(rst), .is_br_i(is_br), .br_mask_i(br_mask),
    .br_state_i(br_state), .br_bit_i(br_bit), .map_i(map_in),
    .fl_head_i(fl_in), .rob_tail_i(rob_in), .alloc_bit_o(alloc_bit),
    .slot_valid_o(slot_valid), .recover_valid_o(recover_valid),
    .map_o(map_out), .fl_head_o(fl_out), .rob_tail_o(rob_out),
    .kill_mask_o(kill_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [MAP_W-1:0] pat(input int s);
    logic [MAP_W-1:0] r;
    r = '0;
    for (int k = 0; k < ARCH_N; k++) r[k*PRF_IDX_W +: PRF_IDX_W] = PRF_IDX_W'((k * 3 + s) & 63);
    return r;
  endfunction

  // Inputs change 1 time unit after the active edge; outputs are sampled there too.
  task automatic applyStimulus(input logic b, input logic [BR_W-1:0] m,
                               input logic [`BR_STATE_W-1:0] st, input logic [BR_W-1:0] bb,
                               input int s);
    is_br = b; br_mask = m; br_state = st; br_bit = bb;
    map_in = pat(s); fl_in = FL_PTR_W'(s + 10); rob_in = ROB_PTR_W'(s + 3);
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic checkOutput(input string tag, input logic [MAP_W-1:0] obs, input logic [MAP_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, `BR_PR_NONE, '0, 0);
  endtask

  task automatic doReset();
    rst = 1'b1; idle(); tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    doReset();
    checkOutput("rst_valid", slot_valid, 0);
    checkOutput("rst_recover", recover_valid, 0);
    checkOutput("rst_kill", kill_mask, 0);
    checkOutput("rst_map", map_out, 0);
    checkOutput("rst_fl", fl_out, 0);
    checkOutput("rst_rob", rob_out, 0);

    // Fill all five slots with chained masks.
    for (int i = 0; i < BR_W; i++) begin
      applyStimulus(1'b1, BR_W'((1 << i) - 1), `BR_PR_NONE, '0, i);
      checkOutput($sformatf("fill_alloc%0d", i), alloc_bit, 1 << i);
      tick();
    end
    checkOutput("fill_valid", slot_valid, 5'b11111);

    applyStimulus(1'b1, 5'b11111, `BR_PR_NONE, '0, 9);
    checkOutput("full_alloc", alloc_bit, 0);
    tick();
    checkOutput("full_valid", slot_valid, 5'b11111);

    // Correct on slot 2 with same-cycle reuse: new slot 2 has dep 11011.
    applyStimulus(1'b1, 5'b11111, `BR_PR_CORRECT, 5'b00100, 7);
    checkOutput("reuse_alloc", alloc_bit, 5'b00100);
    tick();
    checkOutput("reuse_valid", slot_valid, 5'b11111);

    // Wrong on rewritten slot 2 alongside a dispatch: slots 3,4 lost bit 2.
    applyStimulus(1'b1, 5'b11111, `BR_PR_WRONG, 5'b00100, 8);
    checkOutput("wrong_noalloc", alloc_bit, 0);
    tick();
    checkOutput("w2_recover", recover_valid, 1);
    checkOutput("w2_kill", kill_mask, 5'b00100);
    checkOutput("w2_map", map_out, pat(7));
    checkOutput("w2_fl", fl_out, 17);
    checkOutput("w2_rob", rob_out, 10);
    checkOutput("w2_valid", slot_valid, 5'b11011);
    idle(); tick();
    checkOutput("w2_pulse_end", recover_valid, 0);
    checkOutput("w2_kill_end", kill_mask, 0);
    checkOutput("w2_map_hold", map_out, pat(7));
    checkOutput("w2_fl_hold", fl_out, 17);

    // Chained slots 0-3, mispredict slot 1.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, BR_W'((1 << i) - 1), `BR_PR_NONE, '0, 20 + i);
      tick();
    end
    checkOutput("chain_valid", slot_valid, 5'b01111);
    applyStimulus(1'b0, 5'b01111, `BR_PR_WRONG, 5'b00010, 0);
    tick();
    checkOutput("w1_recover", recover_valid, 1);
    checkOutput("w1_kill", kill_mask, 5'b01110);
    checkOutput("w1_map", map_out, pat(21));
    checkOutput("w1_fl", fl_out, 31);
    checkOutput("w1_rob", rob_out, 24);
    checkOutput("w1_valid", slot_valid, 5'b00001);

    // Correct slot 0 first, then mispredict slot 1.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, BR_W'((1 << i) - 1), `BR_PR_NONE, '0, 40 + i);
      tick();
    end
    applyStimulus(1'b0, 5'b01111, `BR_PR_CORRECT, 5'b00001, 0);
    tick();
    checkOutput("c0_valid", slot_valid, 5'b01110);
    applyStimulus(1'b0, 5'b01110, `BR_PR_WRONG, 5'b00010, 0);
    tick();
    checkOutput("c0w1_kill", kill_mask, 5'b01110);
    checkOutput("c0w1_fl", fl_out, 51);
    checkOutput("c0w1_valid", slot_valid, 5'b00000);

    // Reset asserted during the recovery pulse.
    doReset();
    applyStimulus(1'b1, 5'b00000, `BR_PR_NONE, '0, 30);
    tick();
    applyStimulus(1'b0, 5'b00001, `BR_PR_WRONG, 5'b00001, 0);
    tick();
    checkOutput("rp_pulse", recover_valid, 1);
    checkOutput("rp_fl", fl_out, 40);
    rst = 1'b1; idle(); tick();
    checkOutput("rp_recover", recover_valid, 0);
    checkOutput("rp_kill", kill_mask, 0);
    checkOutput("rp_map", map_out, 0);
    checkOutput("rp_fl0", fl_out, 0);
    checkOutput("rp_rob", rob_out, 0);
    checkOutput("rp_valid", slot_valid, 0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/br_checkpoint_stack.md
Name: br_checkpoint_stack

Overview:
- Branch checkpoint storage, directly downstream of the branch mask controller.
- On branch dispatch, snapshots the rename map table, free-list head and ROB tail into the slot given by the first free mask bit.
- On a wrong-path resolution, returns that slot's snapshot one cycle later for recovery and invalidates the slot and every younger slot.
- On a correct resolution, releases the slot and clears that bit from all stored dependency masks.

Parameters:
- BR_W, 5, branch mask width = number of checkpoint slots.
- ARCH_N, 32, architectural registers in the map table.
- PRF_IDX_W, 6, physical register tag width.
- FL_PTR_W, 6, free-list head pointer width.
- ROB_PTR_W, 5, ROB tail pointer width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- is_br_i  in  1  branch dispatched this cycle.
- br_mask_i  in  BR_W  current mask from the mask controller (registered value).
- br_state_i  in  `BR_STATE_W  resolution state: `BR_PR_WRONG / `BR_PR_CORRECT / none.
- br_bit_i  in  BR_W  one-hot bit of the branch resolved this cycle. Ignored when state is none.
- map_i  in  ARCH_N*PRF_IDX_W  current map table, flattened; entry k at [k*PRF_IDX_W +: PRF_IDX_W].
- fl_head_i  in  FL_PTR_W  current free-list head.
- rob_tail_i  in  ROB_PTR_W  ROB tail after the branch is allocated.
- alloc_bit_o  out  BR_W  one-hot slot written this cycle; 0 if none. Combinational.
- slot_valid_o  out  BR_W  registered valid bit per slot.
- recover_valid_o  out  1  one-cycle pulse: recovery data valid.
- map_o  out  ARCH_N*PRF_IDX_W  restored map table.
- fl_head_o  out  FL_PTR_W  restored free-list head.
- rob_tail_o  out  ROB_PTR_W  restored ROB tail.
- kill_mask_o  out  BR_W  slots squashed by the recovery. Valid with recover_valid_o.

Behaviour:
- Per slot storage: valid, dep_mask[BR_W], map, fl_head, rob_tail.
  - dep_mask = br_mask_i at write time, i.e. the mask of older unresolved branches.
- Reset: all valid = 0, all dep_mask = 0. Outputs recover_valid_o = 0, kill_mask_o = 0, map_o = 0, fl_head_o = 0, rob_tail_o = 0, slot_valid_o = 0. Reset dominates any same-cycle event.
- Effective mask: eff = br_mask_i & ~br_bit_i when state is CORRECT; otherwise eff = br_mask_i.
- Allocation:
  - Fires when is_br_i = 1, state != WRONG, and eff != all-ones.
  - Slot = lowest index i with eff[i] = 0; alloc_bit_o = 1<<i, same cycle.
  - Next edge: valid[i] = 1, dep_mask[i] = eff, and map/fl_head/rob_tail captured from the inputs.
  - If eff is all-ones, or state is WRONG, no write and alloc_bit_o = 0. Dispatch is squashed on WRONG.
- CORRECT resolution, slot j = br_bit_i:
  - Next edge: valid[j] = 0.
  - dep_mask[k][j] cleared for all k.
  - Same-cycle allocation into slot j is legal; the write wins, giving valid = 1 with the new contents.
- WRONG resolution, slot j:
  - kill = br_bit_i | {k : valid[k] & dep_mask[k][j]}.
  - Next edge:
    - recover_valid_o = 1.
    - map_o, fl_head_o, rob_tail_o = slot j contents.
    - kill_mask_o = kill.
    - valid[k] = 0 for every k in kill.
  - Latency 1 cycle; recover_valid_o is high for exactly 1 cycle.
  - Restored data holds until the next recovery.
  - kill_mask_o returns to 0 the cycle after the pulse.
- WRONG on a slot with valid = 0 is a protocol error. The block must still produce the pulse with stale data; the bench flags it with an assertion.
- Simultaneous WRONG and CORRECT cannot occur (single resolution port).
- Reset during a recovery pulse clears the pulse on the next edge.
- Slot contents are not cleared on release, only valid.

Test Plan:
- Reset, then 5 dispatches with mask 00000, 00001, 00011, 00111, 01111 -> alloc_bit_o = 00001, 00010, 00100, 01000, 10000; slot_valid_o = 11111.
- Mask 11111 with is_br_i and no resolution -> alloc_bit_o = 0, no slot changes.
- Mask 11111, CORRECT br_bit 00100, is_br_i, new map -> alloc_bit_o = 00100; slot 2 rewritten with dep_mask 11011; valid stays 11111.
- Slots 0-3 chained (each depends on all older), WRONG br_bit 00010 -> next cycle recover_valid_o = 1, map_o/fl_head_o/rob_tail_o = slot 1 snapshot, kill_mask_o = 01110, slot_valid_o = 00001.
- CORRECT on slot 0, then WRONG on slot 1 -> slot 1's dep_mask[0] is already cleared, so kill_mask_o excludes bit 0.
- WRONG concurrent with is_br_i -> no allocation; rst asserted in the pulse cycle -> all outputs 0 next edge.
